// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared definitions for the parametrised UART family:
//                parity mode codes, the frame FSM state encoding and the
//                clocks-per-bit helper. Imported by the transmitter and the
//                baud tick generator, and intended for the matching receiver.
//  Contents    : PARITY_NONE / PARITY_ODD / PARITY_EVEN  parity mode codes
//                uart_state_t                             frame FSM states
//                calc_bps_cnt(clk_freq, bps)              clocks per bit
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

   // Parity mode codes used by the PARITY_MODE parameter.
   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   // One state per field of the serial frame.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   // Clocks per bit, truncated. A zero baud rate yields 0 so the caller's
   // elaboration check rejects it instead of dividing by zero.
   function automatic int calc_bps_cnt(input int clk_freq, input int bps);
      if (bps <= 0) begin
         return 0;
      end
      return clk_freq / bps;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_tick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_tick
//  Description : Bit-period counter. While enabled it counts 0..BPS_CNT-1
//                and wraps, flagging the last count of each bit period with
//                bit_end. The count is free-running across consecutive bits,
//                so bit boundaries never drift. A synchronous clear parks the
//                counter at zero between frames.
//  Ports       : sys_clk    in   system clock, rising edge
//                sys_rst_n  in   asynchronous active-low reset
//                en         in   count enable
//                clr        in   synchronous clear (wins over en)
//                bit_end    out  high during the final cycle of a bit period
//  Revision    : 1.0  initial release
// ============================================================================
module uart_baud_tick #(
   parameter int BPS_CNT = 5208
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic en,
   input  logic clr,
   output logic bit_end
);

   localparam int               CNT_W    = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BPS_CNT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         if (cnt == CNT_LAST) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_ONE;
         end
      end
   end

   // Decoded directly from the count so the FSM can act on the same edge
   // that wraps the counter.
   assign bit_end = en && (cnt == CNT_LAST);

endmodule
`default_nettype wire

// File: rtl/uart_tx_param.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_param
//  Description : Parametrised UART transmitter with a valid/ready upstream
//                handshake. Frame format (data width, parity, stop bits) is
//                fixed at elaboration. Data is sent LSB first.
//  Ports       : sys_clk    in   system clock, rising edge
//                sys_rst_n  in   asynchronous active-low reset
//                tx_valid   in   tx_din holds a frame to send
//                tx_din     in   payload, DATA_BITS wide
//                tx_ready   out  a frame is accepted on this cycle's edge if
//                                tx_valid is high (idle)
//                tx_busy    out  frame in progress
//                tx_done    out  one-cycle pulse when the frame has finished
//                uart_txd   out  serial line, idle high
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_param
   import uart_pkg::*;
#(
   parameter int CLK_FREQ    = 50000000,
   parameter int UART_BPS    = 9600,
   parameter int DATA_BITS   = 8,
   parameter int PARITY_MODE = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic                 tx_valid,
   input  logic [DATA_BITS-1:0] tx_din,
   output logic                 tx_ready,
   output logic                 tx_busy,
   output logic                 tx_done,
   output logic                 uart_txd
);

   localparam int               BPS_CNT    = calc_bps_cnt(CLK_FREQ, UART_BPS);
   localparam int               BIT_W      = $clog2(DATA_BITS + 1);
   localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] BIT_ONE    = BIT_W'(1);
   localparam bit               HAS_PARITY = (PARITY_MODE != PARITY_NONE);
   localparam bit               ODD_PARITY = (PARITY_MODE == PARITY_ODD);
   localparam logic             STOP_LAST  = (STOP_BITS == 2);

   // ------------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ------------------------------------------------------------------------
   generate
      if (BPS_CNT < 2) begin : g_bad_bps_cnt
         $fatal(1, "uart_tx_param: CLK_FREQ/UART_BPS must be at least 2");
      end
      if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data_bits
         $fatal(1, "uart_tx_param: DATA_BITS must be in 5..9");
      end
      if ((PARITY_MODE < PARITY_NONE) || (PARITY_MODE > PARITY_EVEN)) begin : g_bad_parity
         $fatal(1, "uart_tx_param: PARITY_MODE must be 0, 1 or 2");
      end
      if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop_bits
         $fatal(1, "uart_tx_param: STOP_BITS must be 1 or 2");
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Internal state
   // ------------------------------------------------------------------------
   uart_state_t          state;
   logic [DATA_BITS-1:0] shreg;
   logic [BIT_W-1:0]     bit_cnt;
   logic                 stop_cnt;
   logic                 parity_bit;
   logic                 bit_end;
   logic                 xfer;

   assign tx_ready = (state == ST_IDLE);
   assign tx_busy  = (state != ST_IDLE);
   assign xfer     = tx_valid && tx_ready;

   // The bit-period counter runs for the whole frame and is held at zero in
   // IDLE, so the first bit period starts cleanly on the transfer edge.
   uart_baud_tick #(
      .BPS_CNT (BPS_CNT)
   ) u_baud_tick (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .en        (state != ST_IDLE),
      .clr       (state == ST_IDLE),
      .bit_end   (bit_end)
   );

   // ------------------------------------------------------------------------
   // Frame FSM. uart_txd is registered from the current state, so the line
   // lags the state by one clock: the start bit appears on the edge after
   // the transfer, and the final stop bit is still on the line during the
   // cycle in which tx_done pulses and tx_ready is already high. A frame
   // accepted in that cycle therefore leaves exactly one idle-high cycle.
   // ------------------------------------------------------------------------
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state      <= ST_IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         stop_cnt   <= 1'b0;
         parity_bit <= 1'b0;
         uart_txd   <= 1'b1;
         tx_done    <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               uart_txd <= 1'b1;
               if (xfer) begin
                  shreg      <= tx_din;
                  // Even parity bit = XOR of the data; odd is its inverse.
                  parity_bit <= ODD_PARITY ? ~^tx_din : ^tx_din;
                  state      <= ST_START;
               end
            end

            ST_START: begin
               uart_txd <= 1'b0;
               if (bit_end) begin
                  bit_cnt <= '0;
                  state   <= ST_DATA;
               end
            end

            ST_DATA: begin
               uart_txd <= shreg[0];
               if (bit_end) begin
                  shreg   <= shreg >> 1;
                  bit_cnt <= bit_cnt + BIT_ONE;
                  if (bit_cnt == BIT_LAST) begin
                     stop_cnt <= 1'b0;
                     state    <= HAS_PARITY ? ST_PARITY : ST_STOP;
                  end
               end
            end

            ST_PARITY: begin
               uart_txd <= parity_bit;
               if (bit_end) begin
                  stop_cnt <= 1'b0;
                  state    <= ST_STOP;
               end
            end

            ST_STOP: begin
               uart_txd <= 1'b1;
               if (bit_end) begin
                  if (stop_cnt == STOP_LAST) begin
                     tx_done <= 1'b1;
                     state   <= ST_IDLE;
                  end else begin
                     stop_cnt <= 1'b1;
                  end
               end
            end

            default: begin
               uart_txd <= 1'b1;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
